game_round_timer: RTL and testbench

//  Sequences the timed phases of a Tetris Battle round: countdown digit, round clock
//  and KO tally. Watches the 3-bit game status code and derives a 1 Hz tick from clk.

---
 rtl/game_round_timer.sv | 169 ++++++++++++++++
 tb/tb_game_round_timer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/game_round_timer.sv
// Round timer for a Tetris Battle match: countdown digit, BCD round clock and KO tally.
// Behaviour is selected by the game status code; a prescaler derives the 1 Hz tick.
module game_round_timer #(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned CNT_START = 3,
   parameter logic [7:0]  GAME_SECS = 8'h99,
   parameter int unsigned KO_MAX    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] stat_in,
   input  logic       ko_event,
   output logic       tick_1hz,
   output logic [1:0] cntdown_val,
   output logic       cntdown_done,
   output logic [7:0] game_time_bcd,
   output logic       time_up,
   output logic [2:0] ko_count,
   output logic       ko_limit,
   output logic       game_over_req
);

   localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
   localparam logic [2:0] KoLim       = 3'(KO_MAX);
   localparam logic [1:0] CntInit     = 2'(CNT_START);

   typedef enum logic [2:0] {StClear, StLoad, StCount, StPlay, StFreeze} state_e;

   state_e          state;
   logic [2:0]      stat_prev_q, stat_prev_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            tick_q, tick_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            done_q, done_d;
   logic [7:0]      time_q, time_d;
   logic            time_up_q, time_up_d;
   logic [2:0]      ko_q, ko_d;
   logic            ko_limit_q, ko_limit_d;
   logic            gor_q, gor_d;
   logic            phase_change;
   logic            tick_now;

   // Packed-BCD decrement; caller guarantees v != 8'h00.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = v[7:4];
      lo = v[3:0];
      if (lo == 4'd0) begin
         return {hi - 4'd1, 4'd9};
      end
      return {hi, lo - 4'd1};
   endfunction

   // Decode the status code into the timer's operating mode.
   always_comb begin
      state = StClear;
      unique case (stat_in)
         3'b100:  state = StLoad;
         3'b101:  state = StCount;
         3'b110:  state = StPlay;
         3'b111:  state = StFreeze;
         default: state = StClear;
      endcase
   end

   // Next-state logic: prescaler, tick and per-mode counter updates.
   always_comb begin
      stat_prev_d  = stat_in;
      presc_d      = '0;
      tick_d       = 1'b0;
      done_d       = 1'b0;
      cnt_d        = cnt_q;
      time_d       = time_q;
      time_up_d    = time_up_q;
      ko_d         = ko_q;
      ko_limit_d   = ko_limit_q;
      gor_d        = gor_q;
      tick_now     = 1'b0;
      phase_change = (stat_in != stat_prev_q);

      // A phase change restarts the second so the first tick is a full period away.
      if ((state == StCount || state == StPlay) && !phase_change) begin
         tick_now = (presc_q == PresLast);
         presc_d  = tick_now ? '0 : presc_q + PW'(1);
      end

      unique case (state)
         StClear: begin
            cnt_d      = '0;
            time_d     = '0;
            time_up_d  = 1'b0;
            ko_d       = '0;
            ko_limit_d = 1'b0;
            gor_d      = 1'b0;
         end
         StLoad: begin
            cnt_d      = CntInit;
            time_d     = GAME_SECS;
            time_up_d  = 1'b0;
            ko_d       = '0;
            ko_limit_d = 1'b0;
            gor_d      = 1'b0;
         end
         StCount: begin
            tick_d = tick_now;
            gor_d  = time_up_q | ko_limit_q;
            if (tick_now && cnt_q != 2'd0) begin
               cnt_d  = cnt_q - 2'd1;
               done_d = (cnt_q == 2'd1);
            end
         end
         StPlay: begin
            tick_d = tick_now;
            gor_d  = time_up_q | ko_limit_q;
            if (tick_now && time_q != 8'h00) begin
               time_d = bcd_dec(time_q);
            end
            if (ko_event && ko_q != KoLim) begin
               ko_d = ko_q + 3'd1;
            end
            time_up_d  = time_up_q | (time_d == 8'h00);
            ko_limit_d = (ko_d == KoLim);
         end
         StFreeze: begin
            gor_d = time_up_q | ko_limit_q;
         end
         default: ;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_prev_q <= '0;
         presc_q     <= '0;
         tick_q      <= 1'b0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         time_q      <= '0;
         time_up_q   <= 1'b0;
         ko_q        <= '0;
         ko_limit_q  <= 1'b0;
         gor_q       <= 1'b0;
      end else begin
         stat_prev_q <= stat_prev_d;
         presc_q     <= presc_d;
         tick_q      <= tick_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         time_q      <= time_d;
         time_up_q   <= time_up_d;
         ko_q        <= ko_d;
         ko_limit_q  <= ko_limit_d;
         gor_q       <= gor_d;
      end
   end

   assign tick_1hz      = tick_q;
   assign cntdown_val   = cnt_q;
   assign cntdown_done  = done_q;
   assign game_time_bcd = time_q;
   assign time_up       = time_up_q;
   assign ko_count      = ko_q;
   assign ko_limit      = ko_limit_q;
   assign game_over_req = gor_q;

endmodule

// File: tb/tb_game_round_timer.sv
// Bench for game_round_timer: directed phases followed by random status/KO traffic,
// every cycle compared against a seconds-and-ages reference model.
module tb_game_round_timer;

   localparam int unsigned TD    = 4;
   localparam int unsigned CS    = 3;
   localparam logic [7:0]  GS    = 8'h21;
   localparam int unsigned KM    = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] stat_in;
   logic       ko_event;
   logic       tick_1hz;
   logic [1:0] cntdown_val;
   logic       cntdown_done;
   logic [7:0] game_time_bcd;
   logic       time_up;
   logic [2:0] ko_count;
   logic       ko_limit;
   logic       game_over_req;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state: plain integers, seconds in decimal.
   int m_cnt, m_secs, m_ko, m_prev, m_age;
   bit m_tick, m_done, m_tu, m_kl, m_gor;

   game_round_timer #(
      .TICK_DIV (TD),
      .CNT_START(CS),
      .GAME_SECS(GS),
      .KO_MAX   (KM)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stat_in      (stat_in),
      .ko_event     (ko_event),
      .tick_1hz     (tick_1hz),
      .cntdown_val  (cntdown_val),
      .cntdown_done (cntdown_done),
      .game_time_bcd(game_time_bcd),
      .time_up      (time_up),
      .ko_count     (ko_count),
      .ko_limit     (ko_limit),
      .game_over_req(game_over_req)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int s);
      return 8'(((s / 10) * 16) + (s % 10));
   endfunction

   function automatic int from_bcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   // Advance the model by one clock edge using the inputs just sampled.
   task automatic model_edge(input bit r, input int st, input bit ko);
      bit changed, tick, old_flags;
      m_tick = 0;
      m_done = 0;
      if (r) begin
         m_cnt = 0; m_secs = 0; m_ko = 0; m_tu = 0; m_kl = 0; m_gor = 0;
         m_prev = 0; m_age = 0;
         return;
      end
      changed   = (st != m_prev);
      m_prev    = st;
      m_age     = changed ? 0 : m_age + 1;
      tick      = (st == 5 || st == 6) && !changed && m_age > 0 && (m_age % TD) == 0;
      old_flags = m_tu | m_kl;
      if (st < 4) begin
         m_cnt = 0; m_secs = 0; m_ko = 0; m_tu = 0; m_kl = 0; m_gor = 0;
      end else if (st == 4) begin
         m_cnt = CS; m_secs = from_bcd(GS); m_ko = 0; m_tu = 0; m_kl = 0; m_gor = 0;
      end else if (st == 5) begin
         m_tick = tick;
         m_gor  = old_flags;
         if (tick && m_cnt > 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
         end
      end else if (st == 6) begin
         m_tick = tick;
         m_gor  = old_flags;
         if (tick && m_secs > 0) m_secs--;
         if (ko && m_ko < KM) m_ko++;
         m_tu = m_tu | (m_secs == 0);
         m_kl = (m_ko == KM);
      end else begin
         m_gor = old_flags;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tick_1hz",      {7'd0, tick_1hz},      {7'd0, m_tick});
      chk("cntdown_val",   {6'd0, cntdown_val},   8'(m_cnt));
      chk("cntdown_done",  {7'd0, cntdown_done},  {7'd0, m_done});
      chk("game_time_bcd", game_time_bcd,         to_bcd(m_secs));
      chk("time_up",       {7'd0, time_up},       {7'd0, m_tu});
      chk("ko_count",      {5'd0, ko_count},      8'(m_ko));
      chk("ko_limit",      {7'd0, ko_limit},      {7'd0, m_kl});
      chk("game_over_req", {7'd0, game_over_req}, {7'd0, m_gor});
   endtask

   // Drive one cycle of inputs away from the active edge, then check just after it.
   task automatic step(input bit r, input logic [2:0] st, input bit ko);
      @(negedge clk);
      rst      = r;
      stat_in  = st;
      ko_event = ko;
      @(posedge clk);
      model_edge(r, int'(st), ko);
      #1;
      check_all();
   endtask

   initial begin
      bit ko_now;
      logic [2:0] st_r;
      rst = 1'b1; stat_in = 3'b000; ko_event = 1'b0;
      m_cnt = 0; m_secs = 0; m_ko = 0; m_prev = 0; m_age = 0;
      m_tick = 0; m_done = 0; m_tu = 0; m_kl = 0; m_gor = 0;

      // T1: reset then a single LOAD cycle
      step(1'b1, 3'b000, 1'b0);
      step(1'b1, 3'b110, 1'b1);
      chk("t1_reset_time", game_time_bcd, 8'h00);
      step(1'b0, 3'b100, 1'b0);
      chk("t1_load_cnt",  {6'd0, cntdown_val}, 8'd3);
      chk("t1_load_time", game_time_bcd, 8'h21);

      // T2: countdown, with KO pulses that must be ignored
      for (int i = 0; i < 20; i++) step(1'b0, 3'b101, (i % 3) == 0);
      chk("t2_cnt_zero", {6'd0, cntdown_val}, 8'd0);

      // T3: full round to 00 plus extra ticks
      for (int i = 0; i < 100; i++) step(1'b0, 3'b110, 1'b0);
      chk("t3_time_zero", game_time_bcd, 8'h00);
      chk("t3_gor",       {7'd0, game_over_req}, 8'd1);

      // T4: six KOs, one on the first tick of PLAY
      step(1'b0, 3'b100, 1'b0);
      for (int i = 0; i < 16; i++) begin
         ko_now = (i == 1 || i == 3 || i == 4 || i == 6 || i == 8 || i == 10);
         step(1'b0, 3'b110, ko_now);
      end
      chk("t4_ko_sat", {5'd0, ko_count}, 8'd5);

      // T5: KOs in COUNT and FREEZE are ignored; freeze mid-second
      step(1'b0, 3'b100, 1'b0);
      for (int i = 0; i < 6; i++)  step(1'b0, 3'b101, 1'b1);
      for (int i = 0; i < 6; i++)  step(1'b0, 3'b110, i == 2);
      for (int i = 0; i < 12; i++) step(1'b0, 3'b111, 1'b1);
      for (int i = 0; i < 9; i++)  step(1'b0, 3'b110, 1'b0);

      // T6: reset mid-PLAY, then countdown re-entry
      step(1'b0, 3'b110, 1'b1);
      step(1'b1, 3'b110, 1'b1);
      chk("t6_rst_ko", {5'd0, ko_count}, 8'd0);
      step(1'b0, 3'b100, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 3'b101, 1'b0);

      // Random traffic: sticky status codes, frequent KOs, rare resets
      st_r = 3'b100;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) st_r = 3'($urandom_range(0, 7));
         step($urandom_range(0, 299) == 0, st_r, $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
